// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, immediate set, ALU function decode and default widths for the accumulator datapath
package datapath_pkg;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_LOADI  = 8'h02;
  localparam logic [7:0] OP_STORE  = 8'h03;
  localparam logic [7:0] OP_CLR    = 8'h04;
  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_ADDI   = 8'h06;
  localparam logic [7:0] OP_SUB    = 8'h07;
  localparam logic [7:0] OP_SUBI   = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h09;
  localparam logic [7:0] OP_OR     = 8'h0A;
  localparam logic [7:0] OP_XOR    = 8'h0B;
  localparam logic [7:0] OP_SHL    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_ANDI   = 8'h0E;
  localparam logic [7:0] OP_ORI    = 8'h0F;
  localparam logic [7:0] OP_JMP    = 8'h10;
  localparam logic [7:0] OP_JZ     = 8'h11;
  localparam logic [7:0] OP_JN     = 8'h12;
  localparam logic [7:0] OP_JNZ    = 8'h13;
  localparam logic [7:0] OP_PUSH   = 8'h14;
  localparam logic [7:0] OP_POP    = 8'h15;
  localparam logic [7:0] OP_LOADSP = 8'h16;
  localparam logic [7:0] OP_HALT   = 8'h17;
  localparam logic [7:0] OP_JSR    = 8'h18;
  localparam logic [7:0] OP_RTS    = 8'h19;
  typedef enum logic [3:0] {
    ALU_A, ALU_B, ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
  } alu_fn_e;
  // Immediate opcodes take operand B from IRL instead of memory
  function automatic logic is_imm(input logic [7:0] op);
    return op inside {OP_LOADI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI};
  endfunction
  function automatic alu_fn_e alu_decode(input logic [4:0] op);
    case (op)
      5'h01, 5'h02: return ALU_B;
      5'h04:        return ALU_ZERO;
      5'h05, 5'h06: return ALU_ADD;
      5'h07, 5'h08: return ALU_SUB;
      5'h09, 5'h0E: return ALU_AND;
      5'h0A, 5'h0F: return ALU_OR;
      5'h0B:        return ALU_XOR;
      5'h0C:        return ALU_SHL;
      5'h0D:        return ALU_SHR;
      default:      return ALU_A;
    endcase
  endfunction
endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational accumulator ALU, modulo-W arithmetic with no carry out
module datapath_alu #(
  parameter int W = 8
) (
  input  logic [4:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] result
);
  import datapath_pkg::*;
  // Function select from the low five opcode bits
  always_comb begin
    case (alu_decode(op))
      ALU_B:    result = B;
      ALU_ZERO: result = '0;
      ALU_ADD:  result = A + B;
      ALU_SUB:  result = A - B;
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_XOR:  result = A ^ B;
      ALU_SHL:  result = B << 1;
      ALU_SHR:  result = B >> 1;
      default:  result = A;
    endcase
  end
endmodule

// File: rtl/datapath.sv
// datapath: PC/IR/AC/SP registers, memory bus muxing and flags for the accumulator CPU; DATAPATH_STACK_CHECK_EN adds sticky stack error detection
module datapath #(
  parameter int          AW          = 8,
  parameter int          DW          = 8,
  parameter logic [AW-1:0] STACK_LIMIT = 8'hE0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FETCH,
  input  logic          INC_PC,
  input  logic          LOAD_PC,
  input  logic          LOAD_IRU,
  input  logic          LOAD_IRL,
  input  logic          LOAD_AC,
  input  logic          STORE_MEM,
  input  logic          LOAD_SP,
  input  logic          SP_INC,
  input  logic          SP_DEC,
  input  logic          DO_PUSH,
  input  logic          DO_POP,
  input  logic          DO_JSR,
  input  logic          DO_RTS,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WE,
  output logic [7:0]    opcode,
  output logic          ZFLG,
  output logic          NFLG,
  output logic [AW-1:0] PC_Q,
  output logic [AW-1:0] SP_Q,
  output logic [DW-1:0] AC_Q,
  output logic          STK_ERR
);
  import datapath_pkg::*;
  logic [AW-1:0] r_pc, r_sp;
  logic [DW-1:0] r_iru, r_irl, r_ac;
  logic [DW-1:0] w_b, w_alu;
  logic          w_sp_step;
  assign w_b       = is_imm(8'(r_iru)) ? r_irl : MEM_RDATA;
  assign w_sp_step = ~LOAD_SP & (SP_INC ^ SP_DEC);
  assign MEM_ADDR  = FETCH ? r_pc :
                     (DO_PUSH | DO_JSR) ? r_sp - AW'(1) :
                     (DO_POP | DO_RTS) ? r_sp : AW'(r_irl);
  assign MEM_WDATA = DO_JSR ? DW'(r_pc) : r_ac;
  assign MEM_WE    = STORE_MEM & ~RESET;
  assign opcode    = 8'(r_iru);
  assign ZFLG      = r_ac == '0;
  assign NFLG      = r_ac[DW-1];
  assign PC_Q      = r_pc;
  assign SP_Q      = r_sp;
  assign AC_Q      = r_ac;
  datapath_alu #(.W(DW)) u_alu (.op(r_iru[4:0]), .A(r_ac), .B(w_b), .result(w_alu));
  // Architectural registers; load strobes win over increments
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc  <= '0;
      r_sp  <= '0;
      r_iru <= '0;
      r_irl <= '0;
      r_ac  <= '0;
    end else begin
      if (LOAD_IRU) r_iru <= MEM_RDATA;
      if (LOAD_IRL) r_irl <= MEM_RDATA;
      if (LOAD_PC) r_pc <= DO_RTS ? AW'(MEM_RDATA) : AW'(r_irl);
      else if (INC_PC) r_pc <= r_pc + AW'(1);
      if (LOAD_SP) r_sp <= AW'(r_irl);
      else if (w_sp_step) r_sp <= SP_DEC ? r_sp - AW'(1) : r_sp + AW'(1);
      if (LOAD_AC) r_ac <= DO_POP ? MEM_RDATA : w_alu;
    end
  end
`ifdef DATAPATH_STACK_CHECK_EN
  logic r_stk_err;
  // Sticky flag: push past the limit or pop from an empty stack
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_stk_err <= 1'b0;
    else if (w_sp_step && ((SP_DEC && r_sp == STACK_LIMIT) || (SP_INC && r_sp == '0))) r_stk_err <= 1'b1;
  end
  assign STK_ERR = r_stk_err;
`else
  // Folds to constant 0; the reference keeps the limit parameter in use
  assign STK_ERR = 1'b0 & (^STACK_LIMIT);
`endif
endmodule

// File: doc/datapath.md
# datapath

Register-and-ALU datapath driven by the accumulator CPU's control sequencer. It consumes the sequencer's one-hot strobes (FETCH, INC_PC, LOAD_*, STORE_MEM, SP_*, DO_*). It holds PC, IRU, IRL, AC and SP, drives the single-port memory bus, and returns the opcode plus the Z and N flags the sequencer branches on.

## Interface
- Parameters:
  - AW, default 8: address and PC/SP width.
  - DW, default 8: data, AC, IRU and IRL width.
  - STACK_LIMIT, default 8'hE0: lowest legal SP after a push; used only under the configuration macro.
- Ports:
  - CLK in 1: clock. All registers update on posedge; the sequencer updates on negedge.
  - RESET in 1: reset, asynchronous, active-high.
  - FETCH, INC_PC, LOAD_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM in 1 each: sequencer strobes.
  - LOAD_SP, SP_INC, SP_DEC, DO_PUSH, DO_POP, DO_JSR, DO_RTS in 1 each: stack strobes.
  - MEM_RDATA in DW: combinational read data for MEM_ADDR.
  - MEM_ADDR out AW: memory address.
  - MEM_WDATA out DW: memory write data.
  - MEM_WE out 1: write enable; memory captures on posedge.
  - opcode out 8: equals the IRU register.
  - ZFLG out 1: AC == 0.
  - NFLG out 1: AC[DW-1].
  - PC_Q, SP_Q out AW: debug views of PC and SP.
  - AC_Q out DW: debug view of AC.
  - STK_ERR out 1: sticky stack error.

## Operation
- Reset values: PC=0, IRU=0, IRL=0, AC=0, SP=8'h00 (so the first push lands at 8'hFF), STK_ERR=0. Outputs follow: opcode=0, ZFLG=1, NFLG=0, MEM_WE=0.
- MEM_ADDR priority:
  - FETCH: PC.
  - DO_PUSH or DO_JSR: SP-1.
  - DO_POP or DO_RTS: SP.
  - Otherwise: IRL.
- MEM_WE = STORE_MEM. MEM_WDATA = PC when DO_JSR, else AC.
- IR load: LOAD_IRU loads IRU from MEM_RDATA; LOAD_IRL loads IRL from MEM_RDATA. Both asserted together loads both.
- PC: LOAD_PC loads MEM_RDATA when DO_RTS, else IRL. Otherwise INC_PC gives PC+1, wrapping mod 2^AW. LOAD_PC wins over INC_PC.
- SP:
  - LOAD_SP loads IRL.
  - Otherwise SP_DEC gives SP-1 and SP_INC gives SP+1, both wrapping.
  - SP_INC and SP_DEC together leave SP unchanged.
  - LOAD_SP has highest priority.
- AC on LOAD_AC: takes MEM_RDATA when DO_POP, else the ALU result.
- ALU operand B is IRL for immediate opcodes {02,06,08,0E,0F}; otherwise MEM_RDATA at address IRL.
- ALU functions, selected by opcode[4:0]:
  - 00 NOP: AC.
  - 01 LOAD: B.
  - 02 LOADI: B.
  - 04 CLR: 0.
  - 05/06 ADD: AC+B.
  - 07/08 SUB: AC-B.
  - 09 AND: AC&B.
  - 0A OR: AC|B.
  - 0B XOR: AC^B.
  - 0C SHL: B<<1.
  - 0D SHR: B>>1, logical.
  - 0E ANDI: AC&B.
  - 0F ORI: AC|B.
  - Any other value: AC.
- Arithmetic is DW-bit modulo. No carry is kept.
- Return address: JSR pushes PC as it stands after both operand fetches, i.e. the address of the next instruction.

## Timing
- Every strobe is sampled at the posedge inside the sequencer state that asserts it. Each register update therefore takes effect one posedge after the state is entered.
- opcode is registered. IRU loaded at the FetchU posedge is valid at the following negedge, when the sequencer decodes it.
- ZFLG and NFLG are combinational from AC. They are valid the same cycle AC updates, in time for the jump state.
- Read path is zero-latency: MEM_RDATA must settle within the half cycle from negedge to posedge.
- RESET mid-instruction clears all registers immediately and asynchronously. No memory write occurs while RESET is high: MEM_WE is forced to 0.

## Configuration
- DATAPATH_STACK_CHECK_EN defined:
  - STK_ERR is set when SP_DEC is taken with SP == STACK_LIMIT (overflow).
  - STK_ERR is set when SP_INC is taken with SP == 8'h00 (underflow).
  - STK_ERR is sticky and cleared only by RESET.
  - The SP update and memory write still occur.
- Macro not defined: STK_ERR is tied to 0 and no compare logic is built.

## Structure
- Package datapath_pkg holds:
  - Opcode localparams OP_NOP through OP_RTS (8'h00–8'h19).
  - The immediate-opcode set.
  - An ALU function enum.
  - Widths AW and DW.
- One combinational sub-module, datapath_alu (inputs: op, A, B; output: result). All registers and muxes live in datapath.

## Test plan
- Reset: RESET pulse mid-run -> PC=0, SP=0, AC=0, ZFLG=1, MEM_WE=0 while RESET is high.
- Immediate/memory: LOADI 8'h7F then ADDI 8'h01 -> AC=8'h80, NFLG=1, ZFLG=0. Next, M[8'h40]=8'h80 and ADD 8'h40 -> AC=8'h00, ZFLG=1.
- Fetch/PC: INC_PC with PC=8'hFF -> PC=8'h00. LOAD_PC and INC_PC together with IRL=8'h33 -> PC=8'h33.
- Push/pop: SP=0, AC=8'h5A, PUSH -> write 8'h5A to 8'hFF and SP=8'hFF. Then CLR, POP -> AC=8'h5A, SP=8'h00.
- JSR/RTS: PC=8'h12 at JSR with IRL=8'h80 -> M[SP-1]=8'h12, PC=8'h80. Then RTS -> PC=8'h12, SP restored.
- Stack check (macro on): LOADSP 8'hE0 then PUSH -> STK_ERR=1, held until RESET. POP with SP=0 also sets STK_ERR. With macro off, STK_ERR stays 0.
